// File: rtl/serial_operand_tx_pkg.sv
// Shared definitions for the bit-serial MAC operand path: frame state
// encoding and a constant log2 helper, reused by transmitter and receiver.
package serial_operand_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_operand_tx.sv
// Parallel-to-serial operand transmitter: accepts an N-bit operand on a
// valid/ready handshake, sends it LSB-first, then PAD flush bits.
// Build option: SERIAL_TX_SIGN_EXT_EN makes the flush bits copy the operand's
// MSB (sign extension); otherwise flush bits are 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no frame on sd, ready for an operand
// ST_DATA | sd carries operand bit cnt
// ST_PAD  | sd carries a flush bit (frame index cnt >= N)
module serial_operand_tx
  import serial_operand_tx_pkg::*;
#(
  parameter int N   = 8,
  parameter int PAD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         sd,
  output logic         sd_first,
  output logic         sd_last,
  output logic         sd_busy
);

  localparam int LEN = N + PAD;
  localparam int CW  = clog2(LEN) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);
  localparam logic [CW-1:0] N_CW     = CW'(N);

  state_t         state;
  logic [N-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic           pad_bit;
  logic           take;

  // in_ready is only high when idle or on the final frame cycle, so a
  // handshake always means "start a new frame next cycle".
  assign take    = in_valid & in_ready;
  assign cnt_nxt = cnt + CW'(1);

`ifdef SERIAL_TX_SIGN_EXT_EN
  // Capture the operand sign at load for the flush bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_bit <= 1'b0;
    end else if (take) begin
      pad_bit <= in_data[N-1];
    end
  end
`else
  assign pad_bit = 1'b0;
`endif

  // Frame FSM; cnt is the frame index of the bit currently on sd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      sd       <= 1'b0;
      sd_first <= 1'b0;
      sd_last  <= 1'b0;
      sd_busy  <= 1'b0;
      in_ready <= 1'b1;
    end else if (take) begin
      state    <= ST_DATA;
      shreg    <= in_data >> 1;
      cnt      <= '0;
      sd       <= in_data[0];
      sd_first <= 1'b1;
      sd_last  <= 1'b0;
      sd_busy  <= 1'b1;
      in_ready <= 1'b0;
    end else if (state == ST_IDLE) begin
      sd       <= 1'b0;
      sd_first <= 1'b0;
      sd_last  <= 1'b0;
      sd_busy  <= 1'b0;
      in_ready <= 1'b1;
    end else if (sd_last) begin
      state    <= ST_IDLE;
      sd       <= 1'b0;
      sd_first <= 1'b0;
      sd_last  <= 1'b0;
      sd_busy  <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      cnt      <= cnt_nxt;
      sd_first <= 1'b0;
      sd_last  <= (cnt_nxt == LAST_IDX);
      in_ready <= (cnt_nxt == LAST_IDX);
      if (cnt_nxt < N_CW) begin
        state <= ST_DATA;
        sd    <= shreg[0];
        shreg <= shreg >> 1;
      end else begin
        state <= ST_PAD;
        sd    <= pad_bit;
      end
    end
  end

endmodule

// File: doc/serial_operand_tx.md
# serial_operand_tx

Parallel-to-serial operand transmitter for the bit-serial MAC datapath. It accepts an N-bit operand through a valid/ready handshake and emits it LSB-first, one bit per clock. It then appends PAD flush bits so the downstream bit-serial adder tree drains its carries. It drives the single-bit serial operand input of the sequential multiplier and supplies frame strobes so the consumer can align its reset and capture.

## Interface
- N, default 8: operand width in bits, N ≥ 2.
- PAD, default 8: flush cycles appended after the data bits, PAD ≥ 0.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  transmitter can accept an operand this cycle.
- in_data  in  N  operand; sampled only on handshake (in_valid & in_ready).
- sd  out  1  serial data bit.
- sd_first  out  1  high on the cycle sd carries bit 0.
- sd_last  out  1  high on the final cycle of a frame (last pad bit, or bit N-1 when PAD=0).
- sd_busy  out  1  high on every cycle of a frame.

## Operation
- FSM states: IDLE, DATA, PAD.
- IDLE: in_ready=1, sd_busy=0. On handshake: load shift register with in_data, clear counter, go to DATA.
- DATA: sd = shift register bit 0, shift right one bit per cycle, counter increments. After N data cycles go to PAD, or follow the end-of-frame rule below when PAD=0.
- PAD: sd = pad bit (see Configuration), counter runs PAD cycles.
- End of frame, on the sd_last cycle:
  - in_ready=1.
  - Handshake on that cycle → reload and enter DATA next cycle. No bubble.
  - No handshake → IDLE.
- in_ready=0 on every frame cycle except the sd_last cycle. in_valid asserted then is ignored, and in_data is not sampled.
- Counter width is log2(N+PAD)+1 bits. No wrap inside a frame; the counter clears on every load.
- sd, sd_first, sd_last, sd_busy are registered outputs, with no combinational path from in_valid or in_data.
- sd_first and sd_last are both high on one cycle only if N+PAD = 1. This case is excluded by N ≥ 2.

## Timing
- Reset values: in_ready=1, sd=0, sd_first=0, sd_last=0, sd_busy=0, state=IDLE, shift register and counter=0.
- Latency: a handshake at edge t puts bit 0 on sd after edge t, i.e. on cycle t+1.
- Frame length: exactly N+PAD cycles.
- Throughput: one operand per N+PAD cycles when in_valid is held high.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous) and the frame is discarded. After rst_n deasserts, the next rising edge may accept a new operand.
- Outside a frame, sd is forced to 0.

## Configuration
- Macro: SERIAL_TX_SIGN_EXT_EN.
- Defined: pad bits equal the loaded operand's bit N-1, so signed operands are sign-extended through the flush.
- Undefined: pad bits are 0 (unsigned zero-extension).
- Data bits and all timing are identical in both builds.

## Structure
- State enum {IDLE, DATA, PAD} and the log2 constant function go in the shared MAC header/package, so they are reusable by a future serial result receiver.
- Single module, no sub-module. Shift register, counter and FSM are all local.

## Test plan
- Single frame, N=8, PAD=8, in_data=8'hB5 accepted at cycle 0 → sd on cycles 1..8 = 1,0,1,0,1,1,0,1, then 0 on cycles 9..16. sd_first at cycle 1, sd_last at cycle 16, sd_busy on cycles 1..16, in_ready low on cycles 1..15 and high at 16.
- Back-to-back: in_valid held, second word 8'h01 → accepted at cycle 16, sd=1 with sd_first on cycle 17, no idle cycle.
- Mid-frame valid: 8'hFF presented at cycle 4 and held → not accepted until cycle 16; the first frame's bits are unchanged.
- Reset mid-frame: rst_n low at cycle 5 → sd, sd_first, sd_last, sd_busy = 0 immediately, in_ready = 1. After release, 8'h03 is accepted and emitted as 1,1,0,0,0,0,0,0.
- Pad mode: in_data=8'h85 → pad bits all 1 with SERIAL_TX_SIGN_EXT_EN defined, all 0 without.
- PAD=0, N=4, in_data=4'hA → sd = 0,1,0,1, with sd_last on the bit-3 cycle and in_ready high on that same cycle.
